char_select_n: RTL and testbench
================================

CHAR_SELECT_N -- requirements
Module: char_select_n

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 4, number of selectable characters, legal range 2..8.
REQ-002 SHALL have parameter CHAR_W, default 2, width of char output; must satisfy 2**CHAR_W >= NUM_CHARS.
REQ-003 SHALL have port clk25  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk25.
REQ-005 SHALL have port scancode  input  8  PS/2 byte from the keyboard receiver.
REQ-006 SHALL have port scan_valid  input  1  one-cycle strobe; scancode is meaningful only while scan_valid=1.
REQ-007 SHALL have port mode  input  1  0 = direct select, 1 = cycle select.
REQ-008 SHALL have port char  output  CHAR_W  currently selected character index, registered.
REQ-009 SHALL have port active  output  1  a character is selected and enabled, registered.
REQ-010 SHALL have port char_changed  output  1  one-cycle pulse when char or active changes value, registered.

Function
REQ-011 SHALL ignore scancode on every cycle where scan_valid=0; the FSM state and all outputs are held.
REQ-012 SHALL implement FSM states IDLE, BREAK, EXT.
REQ-013 IDLE + valid byte 0xF0 SHALL go to BREAK; IDLE + valid byte 0xE0 SHALL go to EXT; any other valid byte SHALL be decoded and the FSM stays in IDLE.
REQ-014 BREAK + any valid byte SHALL return to IDLE; the byte is discarded (key release).
REQ-015 EXT + valid 0xF0 SHALL go to BREAK; EXT + any other valid byte SHALL return to IDLE with the byte discarded (extended keys unsupported).
REQ-016 Direct mode (mode=0): digit key k (1-based) SHALL set char=k-1 and active=1 when k <= NUM_CHARS; digit scancodes are 1=0x16, 2=0x1E, 3=0x26, 4=0x25, 5=0x2E, 6=0x36, 7=0x3D, 8=0x3E.
REQ-017 Digit keys with k > NUM_CHARS SHALL be ignored in both modes.
REQ-018 Cycle mode (mode=1): Tab (0x0D) SHALL set char = char+1 and active=1, wrapping NUM_CHARS-1 -> 0; digit keys are ignored in this mode.
REQ-019 Cycle mode, Tab while active=0: char SHALL be held and active set to 1 (re-enable without advancing).
REQ-020 Esc (0x76) SHALL set active=0 in both modes; char is held.
REQ-021 Any other decoded byte SHALL leave char and active unchanged.
REQ-022 char and active SHALL update on the clock edge that samples the accepted byte (1-cycle latency from scan_valid to output).
REQ-023 char_changed SHALL be 1 for exactly the cycle after an update in which {char, active} differs from its prior value; a repeat of the same key SHALL NOT pulse it.
REQ-024 A change of mode SHALL take effect on the next accepted byte; FSM state and outputs are unaffected.
REQ-025 Arithmetic on char SHALL be CHAR_W bits wide; wrap is by comparison to NUM_CHARS-1, not by natural overflow.

Reset
REQ-026 reset=0 at a rising edge SHALL force char=0, active=0, char_changed=0, FSM=IDLE.
REQ-027 Reset SHALL take priority over scan_valid on the same edge; a byte presented during reset is discarded.
REQ-028 Reset asserted mid-sequence (BREAK or EXT) SHALL abandon the sequence; the first valid byte after release is decoded from IDLE.

Verification
REQ-029 Direct mode, NUM_CHARS=4: bytes 0x26, then 0xF0, 0x26 -> char=2, active=1 one cycle after the first byte; char_changed pulses once; release produces no change.
REQ-030 Direct mode, NUM_CHARS=4: byte 0x2E (key 5) -> no output change, no char_changed pulse.
REQ-031 Cycle mode, NUM_CHARS=3, start char=2, active=1: Tab -> char=0; Esc -> active=0, char=0; Tab -> active=1, char=0.
REQ-032 Bytes 0xE0, 0x16 -> byte discarded, char unchanged; then 0x16 -> char=0, active=1.
REQ-033 scancode=0x1E held with scan_valid=0 for 10 cycles -> outputs unchanged; one scan_valid pulse -> char=1.
REQ-034 Byte 0xF0, then reset=0 for one cycle, then byte 0x1E -> char=1, active=1 (decoded from IDLE, not treated as a release).

Source files
------------

// File: rtl/char_select_n_if.sv
// Keyboard-side bus for the character selector: scancode strobe and mode in,
// selected character, enable and change pulse out.
interface char_select_n_if #(
  parameter int CHAR_W = 2
);
  logic [7:0]        scancode;
  logic              scan_valid;
  logic              mode;
  logic [CHAR_W-1:0] char;
  logic              active;
  logic              char_changed;

  modport master (
    output scancode, scan_valid, mode,
    input  char, active, char_changed
  );

  modport slave (
    input  scancode, scan_valid, mode,
    output char, active, char_changed
  );
endinterface

// File: rtl/char_select_n.sv
// Character selector driven by PS/2 scancodes.
//
// state | meaning
// IDLE  | waiting for a make code; non-prefix bytes are decoded here
// BREAK | 0xF0 seen; next byte is a key release and is dropped
// EXT   | 0xE0 seen; next byte is an extended key (unsupported, dropped)
//
// Direct mode: digit keys 1..NUM_CHARS select a character and enable it.
// Cycle mode: Tab advances (or re-enables without advancing when disabled).
// Esc disables in both modes. NUM_CHARS must be 2..8 and fit in CHAR_W bits.
module char_select_n #(
  parameter int NUM_CHARS = 4,
  parameter int CHAR_W    = 2
) (
  input  logic             clk25,
  input  logic             reset,
  char_select_n_if.slave   bus
);

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_TAB   = 8'h0D;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [3:0]        NUM_K    = 4'(NUM_CHARS);
  localparam logic [CHAR_W-1:0] LAST_CHR = CHAR_W'(NUM_CHARS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    EXT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              active_q, active_d;
  logic              changed_q, changed_d;

  // Digit make codes map to their 1-based key number; 0 means "not a digit".
  function automatic logic [3:0] digit_of(input logic [7:0] code);
    logic [3:0] k;
    k = 4'd0;
    case (code)
      8'h16: k = 4'd1;
      8'h1E: k = 4'd2;
      8'h26: k = 4'd3;
      8'h25: k = 4'd4;
      8'h2E: k = 4'd5;
      8'h36: k = 4'd6;
      8'h3D: k = 4'd7;
      8'h3E: k = 4'd8;
      default: k = 4'd0;
    endcase
    return k;
  endfunction

  logic [3:0] key_num;
  assign key_num = digit_of(bus.scancode);

  // Next-state and selection update; everything holds unless a byte is strobed.
  always_comb begin
    state_d   = state_q;
    char_d    = char_q;
    active_d  = active_q;
    changed_d = 1'b0;

    if (bus.scan_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.scancode == SC_BREAK) begin
            state_d = BREAK;
          end else if (bus.scancode == SC_EXT) begin
            state_d = EXT;
          end else if (bus.scancode == SC_ESC) begin
            active_d = 1'b0;
          end else if (!bus.mode) begin
            if ((key_num != 4'd0) && (key_num <= NUM_K)) begin
              char_d   = CHAR_W'(key_num - 4'd1);
              active_d = 1'b1;
            end
          end else if (bus.scancode == SC_TAB) begin
            // A disabled selection is re-enabled in place rather than advanced.
            if (active_q) begin
              char_d = (char_q == LAST_CHR) ? '0 : char_q + CHAR_W'(1);
            end
            active_d = 1'b1;
          end
        end
        BREAK: state_d = IDLE;
        EXT:   state_d = (bus.scancode == SC_BREAK) ? BREAK : IDLE;
        default: state_d = IDLE;
      endcase
    end

    changed_d = (char_d != char_q) || (active_d != active_q);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      state_q   <= IDLE;
      char_q    <= '0;
      active_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      char_q    <= char_d;
      active_q  <= active_d;
      changed_q <= changed_d;
    end
  end

  assign bus.char         = char_q;
  assign bus.active       = active_q;
  assign bus.char_changed = changed_q;

endmodule

// File: tb/tb_char_select_n.sv
// Bench for char_select_n: two instances (4 and 3 characters) share stimulus;
// a behavioural model pushes expected outputs, compared one cycle later.
module tb_char_select_n;

  logic clk25 = 1'b0;
  logic reset = 1'b0;
  always #20 clk25 = ~clk25;

  char_select_n_if #(.CHAR_W(2)) if4 ();
  char_select_n_if #(.CHAR_W(2)) if3 ();

  char_select_n #(.NUM_CHARS(4), .CHAR_W(2)) dut4 (
    .clk25 (clk25),
    .reset (reset),
    .bus   (if4)
  );

  char_select_n #(.NUM_CHARS(3), .CHAR_W(2)) dut3 (
    .clk25 (clk25),
    .reset (reset),
    .bus   (if3)
  );

  typedef struct {
    int ch;
    int ac;
    int cg;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  int checks = 0;
  int errors = 0;

  int ms[2];
  int mc[2];
  int ma[2];
  int nch[2];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int key_of(input logic [7:0] b);
    case (b)
      8'h16: return 1;
      8'h1E: return 2;
      8'h26: return 3;
      8'h25: return 4;
      8'h2E: return 5;
      8'h36: return 6;
      8'h3D: return 7;
      8'h3E: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model_step(input int i, input logic [7:0] b,
                                      input logic v, input logic md);
    exp_t e;
    int nc;
    int na;
    int k;
    nc = mc[i];
    na = ma[i];
    if (v) begin
      if (ms[i] == 0) begin
        if (b == 8'hF0) ms[i] = 1;
        else if (b == 8'hE0) ms[i] = 2;
        else begin
          k = key_of(b);
          if (b == 8'h76) na = 0;
          else if (md == 1'b0) begin
            if (k > 0 && k <= nch[i]) begin
              nc = k - 1;
              na = 1;
            end
          end else if (b == 8'h0D) begin
            if (ma[i] == 1) nc = (mc[i] + 1) % nch[i];
            na = 1;
          end
        end
      end else if (ms[i] == 1) begin
        ms[i] = 0;
      end else begin
        ms[i] = (b == 8'hF0) ? 1 : 0;
      end
    end
    e.cg = (nc != mc[i] || na != ma[i]) ? 1 : 0;
    mc[i] = nc;
    ma[i] = na;
    e.ch = nc;
    e.ac = na;
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = 0;
      mc[i] = 0;
      ma[i] = 0;
    end
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (q4.size() == 0 || q3.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
      return;
    end
    e = q4.pop_front();
    chk({tag, ".n4.char"},    int'(if4.char),         e.ch);
    chk({tag, ".n4.active"},  int'(if4.active),       e.ac);
    chk({tag, ".n4.changed"}, int'(if4.char_changed), e.cg);
    e = q3.pop_front();
    chk({tag, ".n3.char"},    int'(if3.char),         e.ch);
    chk({tag, ".n3.active"},  int'(if3.active),       e.ac);
    chk({tag, ".n3.changed"}, int'(if3.char_changed), e.cg);
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic rst_b,
                       input logic md);
    @(negedge clk25);
    reset          = rst_b;
    if4.scancode   = b;
    if3.scancode   = b;
    if4.scan_valid = v;
    if3.scan_valid = v;
    if4.mode       = md;
    if3.mode       = md;
    if (!rst_b) begin
      model_reset();
      q4.push_back('{ch: 0, ac: 0, cg: 0});
      q3.push_back('{ch: 0, ac: 0, cg: 0});
    end else begin
      q4.push_back(model_step(0, b, v, md));
      q3.push_back(model_step(1, b, v, md));
    end
    @(posedge clk25);
    #1;
  endtask

  task automatic byte_in(input string tag, input logic [7:0] b, input logic md);
    drive(b, 1'b1, 1'b1, md);
    compare(tag);
  endtask

  task automatic idle_cyc(input string tag, input logic md);
    drive(8'h00, 1'b0, 1'b1, md);
    compare(tag);
  endtask

  logic [7:0] pool [12];
  logic [7:0] rb;
  logic       rv;
  logic       rm;

  initial begin
    nch[0] = 4;
    nch[1] = 3;
    model_reset();
    if4.scancode = 8'h00; if4.scan_valid = 1'b0; if4.mode = 1'b0;
    if3.scancode = 8'h00; if3.scan_valid = 1'b0; if3.mode = 1'b0;

    // Reset wins over a byte presented on the same edge.
    drive(8'h16, 1'b1, 1'b0, 1'b0);
    compare("reset_with_byte");
    idle_cyc("post_reset", 1'b0);

    // Key 3 press then release.
    byte_in("key3", 8'h26, 1'b0);
    idle_cyc("key3_pulse_clear", 1'b0);
    byte_in("key3_brk", 8'hF0, 1'b0);
    byte_in("key3_rel", 8'h26, 1'b0);

    // Out-of-range digits, and key 4 (valid only for four characters).
    byte_in("key5", 8'h2E, 1'b0);
    byte_in("key4", 8'h25, 1'b0);
    byte_in("key3_again", 8'h26, 1'b0);
    byte_in("key3_repeat", 8'h26, 1'b0);
    byte_in("key8", 8'h3E, 1'b0);

    // Extended prefix discards the next byte.
    byte_in("ext", 8'hE0, 1'b0);
    byte_in("ext_key1", 8'h16, 1'b0);
    byte_in("key1", 8'h16, 1'b0);

    // Byte held without strobe is ignored.
    for (int i = 0; i < 10; i++) begin
      drive(8'h1E, 1'b0, 1'b1, 1'b0);
      compare("hold_no_valid");
    end
    byte_in("key2_strobe", 8'h1E, 1'b0);

    // Extended release: E0 F0 xx drops xx.
    byte_in("ext2", 8'hE0, 1'b0);
    byte_in("ext2_brk", 8'hF0, 1'b0);
    byte_in("ext2_rel", 8'h16, 1'b0);
    byte_in("esc_direct", 8'h76, 1'b0);
    byte_in("key1_b", 8'h16, 1'b0);

    // Reset mid-break: next byte decoded from IDLE.
    byte_in("brk_pre_reset", 8'hF0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    compare("reset_mid_break");
    byte_in("key2_after_reset", 8'h1E, 1'b0);

    // Cycle mode: digits ignored, Tab advances and wraps, Esc/Tab re-enable.
    byte_in("cyc_digit", 8'h16, 1'b1);
    byte_in("tab1", 8'h0D, 1'b1);
    byte_in("tab2", 8'h0D, 1'b1);
    byte_in("tab3", 8'h0D, 1'b1);
    byte_in("esc", 8'h76, 1'b1);
    byte_in("esc_repeat", 8'h76, 1'b1);
    byte_in("tab_reenable", 8'h0D, 1'b1);
    byte_in("other_key", 8'h1C, 1'b1);
    byte_in("tab4", 8'h0D, 1'b1);
    byte_in("tab5", 8'h0D, 1'b1);
    byte_in("tab_brk", 8'hF0, 1'b1);
    byte_in("tab_rel", 8'h0D, 1'b1);
    idle_cyc("mode_switch", 1'b0);
    byte_in("direct_tab", 8'h0D, 1'b0);

    // Randomised traffic against the model.
    pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h3E,
             8'hF0, 8'hE0, 8'h0D, 8'h76, 8'h1C, 8'h0D};
    for (int i = 0; i < 300; i++) begin
      rb = pool[$urandom_range(0, 11)];
      rv = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) begin
        drive(rb, rv, 1'b0, rm);
        compare("rand_reset");
      end else begin
        drive(rb, rv, 1'b1, rm);
        compare("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
